console_writer: RTL and testbench
=================================

// Module: console_writer
// PURPOSE
//  Writer side of the text-mode console: consumes a byte stream (valid/ready) and
//  maintains the character/attribute buffer the console renderer reads.
//  Tracks the cursor and interprets CR/LF/BS/FF. Scrolls by rotating a physical
//  top-row offset (top_row) and blanking the recycled row, so buffer contents are
//  never copied. Sits between a UART/CPU byte source and the text RAM write port.
// PARAMETERS
//  COLUMNS       80     characters per row
//  ROWS          25     rows per screen
//  DEFAULT_ATTR  8'h07  attribute used for blank cells (grey on black)
//  ADDR_W        11     buffer address width; 2**ADDR_W >= COLUMNS*ROWS
// PORTS
//  CLK_PIXEL  in   1       single clock, rising edge
//  reset_n    in   1       asynchronous, active-low reset
//  in_valid   in   1       byte available
//  in_ready   out  1       writer can accept a byte (combinational: state==IDLE)
//  in_char    in   8       byte (ASCII / control)
//  in_attr    in   8       attribute stored with printable bytes
//  wr_en      out  1       buffer write strobe, one cell per cycle
//  wr_addr    out  ADDR_W  cell address = phys_row*COLUMNS + col
//  wr_data    out  16      {attribute, character}
//  cursor_x   out  clog2(COLUMNS)  logical column
//  cursor_y   out  clog2(ROWS)     logical row (0 = top of screen)
//  top_row    out  clog2(ROWS)     physical row shown as logical row 0
// BEHAVIOUR
//  States: CLEAR_ALL, IDLE, CLEAR_ROW. Blank cell = {DEFAULT_ATTR, 8'h20}.
//  Reset: wr_en=0, wr_addr=0, wr_data=0, cursor_x=0, cursor_y=0, top_row=0,
//   state=CLEAR_ALL, clear counter=0. Async assertion aborts any operation,
//   including a partial row clear; buffer is always fully re-cleared.
//  CLEAR_ALL: wr_en=1 for exactly COLUMNS*ROWS cycles, addr 0..COLUMNS*ROWS-1
//   ascending, data = blank. The cycle after the last write: state=IDLE.
//  IDLE: handshake when in_valid & in_ready. All effects appear on registered
//   outputs one cycle later (latency 1). wr_en=0 in any cycle without a write.
//   printable (any byte not listed below): wr_en=1,
//    wr_addr=((top_row+cursor_y) mod ROWS)*COLUMNS+cursor_x (pre-update values),
//    wr_data={in_attr,in_char}; cursor_x++. If cursor_x was COLUMNS-1, apply
//    newline instead of increment (cursor_x=0, then LF rule).
//   8'h0D CR: cursor_x=0, no write.
//   8'h0A LF: cursor_x unchanged. If cursor_y<ROWS-1: cursor_y++.
//    Else scroll: top_row=(top_row+1) mod ROWS, cursor_y stays ROWS-1,
//    state=CLEAR_ROW.
//   8'h08 BS: cursor_x-- if >0; at 0 no change. No write, no erase.
//   8'h0C FF: cursor=(0,0), top_row=0, state=CLEAR_ALL.
//  CLEAR_ROW: wr_en=1 for exactly COLUMNS cycles. Clears the new bottom physical
//   row, (top_row+ROWS-1) mod ROWS (the old top row), cols 0..COLUMNS-1 ascending,
//   data = blank. Then IDLE. in_ready=0 throughout.
//   An autowrapped printable at the bottom row emits its char write first, then
//   the COLUMNS clear writes in the following cycles.
//  Arithmetic: all modulo ops are by compare-and-subtract, never '%'. wr_addr
//   uses a row-base accumulator or a constant multiply; no wrap past
//   COLUMNS*ROWS-1.
//  Simultaneous: in_valid is ignored while in_ready=0; no byte is lost or
//   duplicated. wr_en is never asserted in two states on the same cycle.
// TESTING
//  1 Release reset -> 2000 writes, addr 0..1999, data 16'h0720; then
//    in_ready=1, cursor (0,0), top_row 0.
//  2 Send 'A' (8'h41) with attr 8'h1F -> next cycle wr_en=1, addr 0,
//    data 16'h1F41, cursor_x=1.
//  3 From (0,0) send 80 printables -> last write addr 79, cursor (0,1),
//    no clear cycles.
//  4 At cursor_y=24, top_row=0, send LF -> top_row=1; 80 clear writes addr
//    0..79 data 16'h0720; in_ready low 80 cycles. Then 'B' at x=0 writes addr 0.
//  5 BS at x=0 -> no write, cursor unchanged. CR at x=37 -> x=0, no write.
//  6 FF with top_row=3 -> 2000 clear writes, cursor (0,0), top_row 0. Assert
//    reset_n mid-CLEAR_ROW -> outputs zero at once; full 2000-write clear restarts.

Source files
------------

// File: rtl/console_writer.sv
// Text-mode console writer: byte stream in, character/attribute cells out.
// Scrolling rotates top_row and blanks the recycled row instead of copying.
module console_writer #(
   parameter int         COLUMNS      = 80,
   parameter int         ROWS         = 25,
   parameter logic [7:0] DEFAULT_ATTR = 8'h07,
   parameter int         ADDR_W       = 11,
   localparam int        XW           = $clog2(COLUMNS),
   localparam int        YW           = $clog2(ROWS)
) (
   input  logic              CLK_PIXEL,
   input  logic              reset_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [7:0]        in_char,
   input  logic [7:0]        in_attr,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [15:0]       wr_data,
   output logic [XW-1:0]     cursor_x,
   output logic [YW-1:0]     cursor_y,
   output logic [YW-1:0]     top_row
);

   localparam int          TOTAL = COLUMNS * ROWS;
   localparam logic [15:0] BLANK = {DEFAULT_ATTR, 8'h20};

   typedef enum logic [1:0] {CLEAR_ALL, IDLE, CLEAR_ROW} state_t;

   state_t            r_state, w_state_nxt;
   logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
   logic [ADDR_W-1:0] r_base, w_base_nxt;
   logic              w_en_nxt;
   logic [ADDR_W-1:0] w_addr_nxt;
   logic [15:0]       w_data_nxt;
   logic [XW-1:0]     w_x_nxt;
   logic [YW-1:0]     w_y_nxt;
   logic [YW-1:0]     w_top_nxt;

   logic              w_hs;
   logic              w_lf;
   logic [YW:0]       w_sum;
   logic [YW-1:0]     w_phys;
   logic [YW-1:0]     w_top_inc;
   logic [ADDR_W-1:0] w_cell_addr;
   logic [ADDR_W-1:0] w_top_base;
   logic              w_is_cr, w_is_lf, w_is_bs, w_is_ff;

   assign in_ready = (r_state == IDLE);
   assign w_hs     = in_valid & in_ready;

   assign w_is_cr = (in_char == 8'h0D);
   assign w_is_lf = (in_char == 8'h0A);
   assign w_is_bs = (in_char == 8'h08);
   assign w_is_ff = (in_char == 8'h0C);

   // Physical row of the cursor, wrapped by compare-and-subtract
   assign w_sum  = {1'b0, top_row} + {1'b0, cursor_y};
   assign w_phys = (w_sum >= (YW+1)'(ROWS)) ?
                   w_sum[YW-1:0] - YW'(ROWS) : w_sum[YW-1:0];

   assign w_top_inc = (top_row == YW'(ROWS-1)) ?
                      '0 : top_row + YW'(1);

   assign w_cell_addr = ADDR_W'(w_phys) * ADDR_W'(COLUMNS)
                      + ADDR_W'(cursor_x);
   assign w_top_base  = ADDR_W'(top_row) * ADDR_W'(COLUMNS);

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_base_nxt  = r_base;
      w_en_nxt    = 1'b0;
      w_addr_nxt  = wr_addr;
      w_data_nxt  = wr_data;
      w_x_nxt     = cursor_x;
      w_y_nxt     = cursor_y;
      w_top_nxt   = top_row;
      w_lf        = 1'b0;
      unique case (r_state)
         CLEAR_ALL: begin
            w_en_nxt   = 1'b1;
            w_addr_nxt = r_cnt;
            w_data_nxt = BLANK;
            if (r_cnt == ADDR_W'(TOTAL-1)) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + ADDR_W'(1);
            end
         end
         CLEAR_ROW: begin
            w_en_nxt   = 1'b1;
            w_addr_nxt = r_base + r_cnt;
            w_data_nxt = BLANK;
            if (r_cnt == ADDR_W'(COLUMNS-1)) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = '0;
            end else begin
               w_cnt_nxt = r_cnt + ADDR_W'(1);
            end
         end
         IDLE: begin
            if (w_hs) begin
               unique case (1'b1)
                  w_is_cr: w_x_nxt = '0;
                  w_is_lf: w_lf = 1'b1;
                  w_is_bs: begin
                     if (cursor_x != '0)
                        w_x_nxt = cursor_x - XW'(1);
                  end
                  w_is_ff: begin
                     w_x_nxt     = '0;
                     w_y_nxt     = '0;
                     w_top_nxt   = '0;
                     w_cnt_nxt   = '0;
                     w_state_nxt = CLEAR_ALL;
                  end
                  default: begin
                     w_en_nxt   = 1'b1;
                     w_addr_nxt = w_cell_addr;
                     w_data_nxt = {in_attr, in_char};
                     if (cursor_x == XW'(COLUMNS-1)) begin
                        w_x_nxt = '0;
                        w_lf    = 1'b1;
                     end else begin
                        w_x_nxt = cursor_x + XW'(1);
                     end
                  end
               endcase
               // Bottom-row LF: the old top row becomes the new bottom row
               if (w_lf) begin
                  if (cursor_y != YW'(ROWS-1)) begin
                     w_y_nxt = cursor_y + YW'(1);
                  end else begin
                     w_top_nxt   = w_top_inc;
                     w_base_nxt  = w_top_base;
                     w_cnt_nxt   = '0;
                     w_state_nxt = CLEAR_ROW;
                  end
               end
            end
         end
         default: begin
            w_state_nxt = CLEAR_ALL;
            w_cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge CLK_PIXEL or negedge reset_n) begin
      if (!reset_n) begin
         r_state  <= CLEAR_ALL;
         r_cnt    <= '0;
         r_base   <= '0;
         wr_en    <= 1'b0;
         wr_addr  <= '0;
         wr_data  <= '0;
         cursor_x <= '0;
         cursor_y <= '0;
         top_row  <= '0;
      end else begin
         r_state  <= w_state_nxt;
         r_cnt    <= w_cnt_nxt;
         r_base   <= w_base_nxt;
         wr_en    <= w_en_nxt;
         wr_addr  <= w_addr_nxt;
         wr_data  <= w_data_nxt;
         cursor_x <= w_x_nxt;
         cursor_y <= w_y_nxt;
         top_row  <= w_top_nxt;
      end
   end

endmodule

// File: tb/tb_console_writer.sv
// Scoreboard bench for console_writer: a cursor/scroll model queues
// every expected buffer write; a monitor pops and compares them.
module tb_console_writer;

   logic        CLK_PIXEL = 1'b0;
   logic        reset_n   = 1'b0;
   logic        in_valid  = 1'b0;
   logic [7:0]  in_char   = 8'h00;
   logic [7:0]  in_attr   = 8'h00;
   logic        in_ready;
   logic        wr_en;
   logic [10:0] wr_addr;
   logic [15:0] wr_data;
   logic [6:0]  cursor_x;
   logic [4:0]  cursor_y;
   logic [4:0]  top_row;

   console_writer dut (
      .CLK_PIXEL (CLK_PIXEL),
      .reset_n   (reset_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_char   (in_char),
      .in_attr   (in_attr),
      .wr_en     (wr_en),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .cursor_x  (cursor_x),
      .cursor_y  (cursor_y),
      .top_row   (top_row)
   );

   always #5 CLK_PIXEL = ~CLK_PIXEL;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [26:0] sb[$];
   int          m_x = 0;
   int          m_y = 0;
   int          m_top = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   always @(negedge CLK_PIXEL) begin
      if (reset_n && wr_en) begin
         if (sb.size() == 0) begin
            check("unexp_wr", {21'd0, wr_addr}, 32'hFFFF_FFFF);
         end else begin
            logic [26:0] e;
            e = sb.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(e[26:16]));
            check("wr_data", 32'(wr_data), 32'(e[15:0]));
         end
      end
   end

   task automatic push_blank_all();
      for (int i = 0; i < 2000; i++)
         sb.push_back({11'(i), 16'h0720});
   endtask

   task automatic push_blank_row(input int r);
      for (int c = 0; c < 80; c++)
         sb.push_back({11'(r * 80 + c), 16'h0720});
   endtask

   task automatic model_lf();
      if (m_y < 24) begin
         m_y++;
      end else begin
         push_blank_row(m_top);
         m_top = (m_top + 1) % 25;
      end
   endtask

   task automatic send(input logic [7:0] c, input logic [7:0] a);
      int n;
      n = 0;
      @(negedge CLK_PIXEL);
      while (!in_ready && n < 5000) begin
         @(negedge CLK_PIXEL);
         n++;
      end
      if (!in_ready) begin
         check("rdy_timeout", 32'(in_ready), 32'd1);
         return;
      end
      case (c)
         8'h0D: m_x = 0;
         8'h0A: model_lf();
         8'h08: if (m_x > 0) m_x--;
         8'h0C: begin
            m_x = 0;
            m_y = 0;
            m_top = 0;
            push_blank_all();
         end
         default: begin
            sb.push_back({11'(((m_top + m_y) % 25) * 80 + m_x), a, c});
            if (m_x == 79) begin
               m_x = 0;
               model_lf();
            end else begin
               m_x++;
            end
         end
      endcase
      in_valid = 1'b1;
      in_char  = c;
      in_attr  = a;
      @(posedge CLK_PIXEL);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 3000) begin
         @(negedge CLK_PIXEL);
         n++;
      end
      check("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic check_cur();
      check("cur_x", 32'(cursor_x), m_x);
      check("cur_y", 32'(cursor_y), m_y);
      check("top", 32'(top_row), m_top);
   endtask

   initial begin
      int lo;
      reset_n = 1'b0;
      repeat (3) @(negedge CLK_PIXEL);
      check("rst_en", 32'(wr_en), 32'd0);
      check("rst_addr", 32'(wr_addr), 32'd0);
      check("rst_data", 32'(wr_data), 32'd0);
      reset_n = 1'b1;
      push_blank_all();
      drain();
      check("rdy_init", 32'(in_ready), 32'd1);
      check_cur();

      send(8'h41, 8'h1F);
      check("a_en", 32'(wr_en), 32'd1);
      check("a_addr", 32'(wr_addr), 32'd0);
      check("a_data", 32'(wr_data), 32'h1F41);
      check_cur();

      send(8'h0D, 8'h00);
      check_cur();
      send(8'h0C, 8'h00);
      check_cur();
      drain();

      for (int i = 0; i < 80; i++)
         send(8'h61 + 8'(i % 26), 8'h0E);
      check_cur();
      check("row_wr_y", 32'(cursor_y), 32'd1);
      drain();

      for (int i = 0; i < 23; i++)
         send(8'h0A, 8'h00);
      check_cur();
      send(8'h0A, 8'h00);
      check_cur();
      lo = 0;
      @(negedge CLK_PIXEL);
      while (!in_ready && lo < 200) begin
         lo++;
         @(negedge CLK_PIXEL);
      end
      check("busy_cycles", lo, 32'd80);
      drain();

      send(8'h42, 8'h1F);
      check("b_en", 32'(wr_en), 32'd1);
      check("b_addr", 32'(wr_addr), 32'd0);
      check("b_data", 32'(wr_data), 32'h1F42);

      send(8'h08, 8'h00);
      send(8'h08, 8'h00);
      check("bs_en", 32'(wr_en), 32'd0);
      check_cur();

      for (int i = 0; i < 37; i++)
         send(8'h30 + 8'(i % 10), 8'h2A);
      check_cur();
      send(8'h0D, 8'h00);
      check("cr_en", 32'(wr_en), 32'd0);
      check_cur();

      send(8'h0A, 8'h00);
      send(8'h0A, 8'h00);
      drain();
      check_cur();
      send(8'h0C, 8'h00);
      check_cur();
      drain();

      for (int i = 0; i < 24; i++)
         send(8'h0A, 8'h00);
      for (int i = 0; i < 80; i++)
         send(8'h41 + 8'(i % 26), 8'h4E);
      drain();
      check_cur();

      send(8'h0A, 8'h00);
      repeat (10) @(negedge CLK_PIXEL);
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_en", 32'(wr_en), 32'd0);
      check("mid_addr", 32'(wr_addr), 32'd0);
      check("mid_data", 32'(wr_data), 32'd0);
      check("mid_rdy", 32'(in_ready), 32'd0);
      sb.delete();
      m_x = 0;
      m_y = 0;
      m_top = 0;
      check_cur();
      repeat (2) @(negedge CLK_PIXEL);
      reset_n = 1'b1;
      push_blank_all();
      drain();
      check("rdy_final", 32'(in_ready), 32'd1);
      check_cur();

      repeat (3) @(negedge CLK_PIXEL);
      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
